// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception sequencer: commit codes, CP0 bit positions,
// FSM states and stall vectors.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_CODE_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_CODE_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_CODE_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_CODE_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_CODE_ERET    = 32'h0000_000e;

    localparam int unsigned CP0_IE    = 0;
    localparam int unsigned CP0_EXL   = 1;
    localparam int unsigned CP0_IM_LO = 8;
    localparam int unsigned CP0_IM_HI = 15;
    localparam int unsigned CP0_IP_LO = 8;
    localparam int unsigned CP0_IP_HI = 15;
    localparam int unsigned CP0_BEV   = 22;

    localparam logic [31:0] VEC_BOOT   = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORMAL = 32'h8000_0180;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_RECOVER
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority exception selector: interrupt > RI > syscall > eret.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        int_pending,
    input  logic        req_ri,
    input  logic        req_syscall,
    input  logic        req_eret,
    output logic [31:0] code
);

    always_comb begin
        code = EXC_CODE_NONE;
        if (int_pending)      code = EXC_CODE_INT;
        else if (req_ri)      code = EXC_CODE_RI;
        else if (req_syscall) code = EXC_CODE_SYSCALL;
        else if (req_eret)    code = EXC_CODE_ERET;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: RUN -> FLUSH -> RECOVER commit sequence plus stall merge.
// Build option EXC_CTRL_BEV_EN selects the vector from Status[BEV] instead of EXC_VECTOR.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        req_syscall_i,
    input  logic        req_ri_i,
    input  logic        req_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o
);

    state_t      state, state_next;
    logic [31:0] code, code_q, pc_q, vector;
    logic        ds_q, int_pending, accept;
    logic        unused_bits;

    assign unused_bits = ^{cp0_status_i, cp0_cause_i};

    assign int_pending = cp0_status_i[CP0_IE] & ~cp0_status_i[CP0_EXL]
                       & (|(cp0_cause_i[CP0_IP_HI:CP0_IP_LO] & cp0_status_i[CP0_IM_HI:CP0_IM_LO]));

    exc_prio_enc u_prio (
        .int_pending (int_pending),
        .req_ri      (req_ri_i),
        .req_syscall (req_syscall_i),
        .req_eret    (req_eret_i),
        .code        (code)
    );

`ifdef EXC_CTRL_BEV_EN
    assign vector = cp0_status_i[CP0_BEV] ? VEC_BOOT : VEC_NORMAL;
`else
    assign vector = EXC_VECTOR;
`endif

    // Bubbles and memory stalls leave the event pending for a later RUN cycle.
    assign accept = (state == ST_RUN) && mem_valid_i && !stallreq_mem_i
                 && (code != EXC_CODE_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            code_q <= '0;
            pc_q   <= '0;
            ds_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                code_q <= code;
                pc_q   <= mem_pc_i;
                ds_q   <= mem_in_delayslot_i;
            end
        end
    end

    always_comb begin
        state_next          = state;
        flush_o             = 1'b0;
        new_pc_o            = '0;
        excepttype_o        = EXC_CODE_NONE;
        current_inst_addr_o = '0;
        is_in_delayslot_o   = 1'b0;
        if (stallreq_mem_i)     stall_o = STALL_MEM;
        else if (stallreq_ex_i) stall_o = STALL_EX;
        else if (stallreq_id_i) stall_o = STALL_ID;
        else if (stallreq_if_i) stall_o = STALL_IF;
        else                    stall_o = STALL_NONE;

        case (state)
            ST_RUN: begin
                if (accept) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_o             = 1'b1;
                stall_o             = STALL_NONE;
                excepttype_o        = code_q;
                current_inst_addr_o = pc_q;
                is_in_delayslot_o   = ds_q;
                new_pc_o            = (code_q == EXC_CODE_ERET) ? cp0_epc_i : vector;
                state_next          = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, hand sequences, and a
// randomized run against a countdown-based reference model.
module tb_exc_ctrl;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic        sys;
        logic        ri;
        logic        eret;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [3:0]  sreq;   // {mem, ex, id, if}
    } in_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] etype;
        logic [31:0] addr;
        logic        ds;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string name;
    } vec_t;

    logic        clk;
    logic        rst;
    in_t         din;
    out_t        dout;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o, excepttype_o, current_inst_addr_o;
    logic        is_in_delayslot_o;

    int nerr = 0;
    int nchecks = 0;

    exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (din.valid),
        .mem_pc_i            (din.pc),
        .mem_in_delayslot_i  (din.ds),
        .req_syscall_i       (din.sys),
        .req_ri_i            (din.ri),
        .req_eret_i          (din.eret),
        .cp0_status_i        (din.status),
        .cp0_cause_i         (din.cause),
        .cp0_epc_i           (din.epc),
        .stallreq_if_i       (din.sreq[0]),
        .stallreq_id_i       (din.sreq[1]),
        .stallreq_ex_i       (din.sreq[2]),
        .stallreq_mem_i      (din.sreq[3]),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o)
    );

    assign dout = {stall_o, flush_o, new_pc_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mi(logic valid, logic [31:0] pc, logic ds, logic sys, logic ri,
                               logic eret, logic [31:0] status, logic [31:0] cause,
                               logic [31:0] epc, logic [3:0] sreq);
        in_t x;
        x.valid = valid; x.pc = pc; x.ds = ds; x.sys = sys; x.ri = ri; x.eret = eret;
        x.status = status; x.cause = cause; x.epc = epc; x.sreq = sreq;
        return x;
    endfunction

    function automatic logic [31:0] vec(logic [31:0] status);
`ifdef EXC_CTRL_BEV_EN
        return status[22] ? 32'hBFC0_0380 : 32'h8000_0180;
`else
        return 32'h0000_0020;
`endif
    endfunction

    function automatic out_t zo(logic [3:0] sreq);
        out_t o;
        o = '0;
        if (sreq[3])      o.stall = 6'b011111;
        else if (sreq[2]) o.stall = 6'b001111;
        else if (sreq[1]) o.stall = 6'b000111;
        else if (sreq[0]) o.stall = 6'b000011;
        return o;
    endfunction

    function automatic out_t commit(logic [31:0] code, logic [31:0] pc, logic ds,
                                    logic [31:0] epc, logic [31:0] status);
        out_t o;
        o.stall  = 6'b000000;
        o.flush  = 1'b1;
        o.new_pc = (code == 32'he) ? epc : vec(status);
        o.etype  = code;
        o.addr   = pc;
        o.ds     = ds;
        return o;
    endfunction

    function automatic logic [31:0] ref_code(in_t x);
        logic intp;
        intp = x.status[0] && !x.status[1] && ((x.cause[15:8] & x.status[15:8]) != 8'h00);
        if (intp)   return 32'h1;
        if (x.ri)   return 32'ha;
        if (x.sys)  return 32'h8;
        if (x.eret) return 32'he;
        return 32'h0;
    endfunction

    task automatic check(out_t exp, string name);
        nchecks++;
        if (dout !== exp) begin
            nerr++;
            $display("FAIL %s: got stall=%b flush=%b new_pc=%h type=%h addr=%h ds=%b; expected stall=%b flush=%b new_pc=%h type=%h addr=%h ds=%b",
                     name, dout.stall, dout.flush, dout.new_pc, dout.etype, dout.addr, dout.ds,
                     exp.stall, exp.flush, exp.new_pc, exp.etype, exp.addr, exp.ds);
        end
    endtask

    task automatic cyc(in_t x, out_t exp, string name);
        din = x;
        @(negedge clk);
        check(exp, name);
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[$];
    in_t         x;
    out_t        exp;
    int          busy;
    logic [31:0] m_code, m_pc, c;
    logic        m_ds;

    initial begin
        din = '0;
        rst = 1'b0;
        #12;
        @(negedge clk);
        check(zo(4'b0000), "reset_state");
        @(posedge clk);
        #1 rst = 1'b1;

        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001), zo(4'b0001), "stall_if"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010), zo(4'b0010), "stall_id"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100), zo(4'b0100), "stall_ex"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010), zo(4'b1010), "stall_mem_id"});
        tbl.push_back('{mi(1, 32'h100, 0, 1, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "sys_accept"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001), commit(32'h8, 32'h100, 0, 0, 0), "sys_flush"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001), zo(4'b0001), "sys_recover"});
        tbl.push_back('{mi(1, 32'h300, 1, 0, 0, 1, 0, 0, 32'h400, 4'b0000), zo(4'b0000), "eret_accept"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h400, 4'b0000), commit(32'he, 32'h300, 1, 32'h400, 0), "eret_flush"});
        tbl.push_back('{mi(1, 32'h340, 0, 1, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "recover_ignores"});
        tbl.push_back('{mi(1, 32'h340, 0, 1, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "run_takes_held"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), commit(32'h8, 32'h340, 0, 0, 0), "held_flush"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "held_recover"});
        tbl.push_back('{mi(0, 32'h380, 0, 1, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "bubble_syscall"});
        tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "bubble_no_flush"});
        foreach (tbl[k]) cyc(tbl[k].i, tbl[k].o, tbl[k].name);

        // interrupt held across a MEM bubble, taken on first valid instruction
        for (int k = 0; k < 3; k++)
            cyc(mi(0, 32'h1f0, 0, 0, 0, 0, 32'h401, 32'h400, 0, 4'b0000), zo(4'b0000), "int_bubble");
        cyc(mi(1, 32'h200, 0, 0, 0, 0, 32'h401, 32'h400, 0, 4'b0000), zo(4'b0000), "int_accept");
        cyc(mi(1, 32'h204, 0, 0, 0, 0, 32'h403, 32'h400, 0, 4'b0000), commit(32'h1, 32'h200, 0, 0, 32'h403), "int_flush");
        cyc(mi(1, 32'h204, 0, 0, 0, 0, 32'h403, 32'h400, 0, 4'b0000), zo(4'b0000), "int_recover");
        cyc(mi(1, 32'h204, 0, 0, 0, 0, 32'h403, 32'h400, 0, 4'b0000), zo(4'b0000), "int_masked_exl");
        cyc(mi(1, 32'h208, 0, 0, 0, 0, 32'h403, 32'h400, 0, 4'b0000), zo(4'b0000), "int_masked_no_flush");

        // RI and interrupt together: interrupt first, RI after FLUSH+RECOVER
        cyc(mi(1, 32'h500, 0, 0, 1, 0, 32'h401, 32'h400, 0, 4'b0000), zo(4'b0000), "ri_int_accept");
        cyc(mi(1, 32'h500, 0, 0, 1, 0, 32'h403, 32'h400, 0, 4'b0000), commit(32'h1, 32'h500, 0, 0, 32'h403), "ri_int_flush_int");
        cyc(mi(1, 32'h500, 0, 0, 1, 0, 32'h403, 32'h400, 0, 4'b0000), zo(4'b0000), "ri_int_recover");
        cyc(mi(1, 32'h500, 0, 0, 1, 0, 32'h403, 32'h400, 0, 4'b0000), zo(4'b0000), "ri_accept");
        cyc(mi(0, 0, 0, 0, 0, 0, 32'h403, 32'h400, 0, 4'b0000), commit(32'ha, 32'h500, 0, 0, 32'h403), "ri_flush");
        cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "ri_recover");

        // syscall deferred by a memory stall
        for (int k = 0; k < 4; k++)
            cyc(mi(1, 32'h600, 0, 1, 0, 0, 0, 0, 0, 4'b1000), zo(4'b1000), "stall_defers");
        cyc(mi(1, 32'h600, 0, 1, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "stall_clear_accept");
        cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), commit(32'h8, 32'h600, 0, 0, 0), "stall_late_flush");
        cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), zo(4'b0000), "stall_recover");

        // reset in FLUSH discards the commit; BEV set for the vector check
        cyc(mi(1, 32'h700, 0, 1, 0, 0, 32'h0040_0000, 0, 0, 4'b0000), zo(4'b0000), "rst_accept");
        din = mi(0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 4'b0000);
        @(negedge clk);
        check(commit(32'h8, 32'h700, 0, 0, 32'h0040_0000), "rst_flush_bev");
        #1 rst = 1'b0;
        #1 check(zo(4'b0000), "reset_in_flush");
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(mi(0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 4'b0000), zo(4'b0000), "no_commit_after_reset");
        cyc(mi(0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 4'b0000), zo(4'b0000), "no_commit_after_reset2");

        // randomized run: busy counts down the two cycles after an accept
        busy = 0; m_code = '0; m_pc = '0; m_ds = 1'b0;
        for (int n = 0; n < 600; n++) begin
            x.valid  = ($urandom_range(0, 3) != 0);
            x.pc     = $urandom & 32'hFFFF_FFFC;
            x.ds     = $urandom_range(0, 1) == 1;
            x.sys    = ($urandom_range(0, 4) == 0);
            x.ri     = ($urandom_range(0, 6) == 0);
            x.eret   = ($urandom_range(0, 4) == 0);
            x.status = $urandom & 32'h0040_FF03;
            x.cause  = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_FC00) : 32'h0;
            x.epc    = $urandom;
            for (int b = 0; b < 4; b++) x.sreq[b] = ($urandom_range(0, 7) == 0);
            exp = (busy == 2) ? commit(m_code, m_pc, m_ds, x.epc, x.status) : zo(x.sreq);
            cyc(x, exp, "random");
            if (busy > 0) busy--;
            else if (x.valid && !x.sreq[3]) begin
                c = ref_code(x);
                if (c != 32'h0) begin
                    m_code = c; m_pc = x.pc; m_ds = x.ds; busy = 2;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
